// File: rtl/seq_alu.sv
// seq_alu: registered ALU with single-cycle logic/arith ops, shift-add multiply
// and (when SEQ_ALU_DIV_EN is defined) a restoring divider, one bit per cycle.
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [1:0] DIV  = 2'd2;
`endif

  logic [1:0]       state_q;
  logic [WIDTH-1:0] work_hi_q, work_lo_q, operand_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] result_q, hi_q;
  logic             overflow_q, done_q;

  logic [WIDTH-1:0] alu_res_d, sum_d, diff_d;
  logic             alu_ovf_d;
  logic [WIDTH-1:0] iter_hi_d, iter_lo_d;
  logic [WIDTH:0]   mul_sum_d;
`ifdef SEQ_ALU_DIV_EN
  logic [WIDTH:0]   rem_shift_d;
  logic [WIDTH-1:0] rem_sub_d;
  logic             rem_ge_d;
`endif

  always_comb begin
    sum_d     = a + b;
    diff_d    = a - b;
    alu_res_d = '0;
    alu_ovf_d = 1'b0;
    case (alu_control)
      4'b0000: alu_res_d = a & b;
      4'b0001: alu_res_d = a | b;
      4'b0010: begin
        alu_res_d = sum_d;
        alu_ovf_d = (a[WIDTH-1] == b[WIDTH-1]) && (sum_d[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0110: begin
        alu_res_d = diff_d;
        alu_ovf_d = (a[WIDTH-1] != b[WIDTH-1]) && (diff_d[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0111: alu_res_d[0] = $signed(a) < $signed(b);
      4'b1000: alu_res_d[0] = a < b;
      4'b1100: alu_res_d = ~(a | b);
      default: alu_res_d = '0;
    endcase
  end

  // One iteration step: multiply shifts the running product right, adding the
  // multiplicand when the next multiplier bit is set; divide shifts the
  // remainder left and subtracts the divisor when it fits.
  always_comb begin
    mul_sum_d = {1'b0, work_hi_q} + (work_lo_q[0] ? {1'b0, operand_q} : '0);
    iter_hi_d = mul_sum_d[WIDTH:1];
    iter_lo_d = {mul_sum_d[0], work_lo_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    rem_shift_d = {work_hi_q, work_lo_q[WIDTH-1]};
    rem_ge_d    = rem_shift_d >= {1'b0, operand_q};
    rem_sub_d   = rem_shift_d[WIDTH-1:0] - operand_q;
    if (state_q == DIV) begin
      iter_hi_d = rem_ge_d ? rem_sub_d : rem_shift_d[WIDTH-1:0];
      iter_lo_d = {work_lo_q[WIDTH-2:0], rem_ge_d};
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      work_hi_q  <= '0;
      work_lo_q  <= '0;
      operand_q  <= '0;
      count_q    <= '0;
      result_q   <= '0;
      hi_q       <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            count_q   <= '0;
            work_hi_q <= '0;
            case (alu_control)
              4'b1001: begin
                state_q   <= MUL;
                work_lo_q <= b;
                operand_q <= a;
              end
`ifdef SEQ_ALU_DIV_EN
              4'b1010: begin
                state_q   <= DIV;
                work_lo_q <= a;
                operand_q <= b;
              end
`endif
              default: begin
                result_q   <= alu_res_d;
                overflow_q <= alu_ovf_d;
                done_q     <= 1'b1;
              end
            endcase
          end
        end
        default: begin
          // Multi-cycle op: the last of WIDTH iterations publishes the result.
          work_hi_q <= iter_hi_d;
          work_lo_q <= iter_lo_d;
          count_q   <= count_q + CW'(1);
          if (count_q == CW'(WIDTH - 1)) begin
            state_q    <= IDLE;
            result_q   <= iter_lo_d;
            hi_q       <= iter_hi_d;
            overflow_q <= 1'b0;
            done_q     <= 1'b1;
          end
        end
      endcase
    end
  end

  assign result   = result_q;
  assign hi       = hi_q;
  assign zero     = (result_q == '0);
  assign overflow = overflow_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: scoreboard bench for seq_alu at WIDTH=32 and WIDTH=8; honours
// SEQ_ALU_DIV_EN to choose the expected behaviour of code 1010.
module tb_seq_alu;

`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start32, start8;
  logic [31:0] a32, b32, result32, hi32;
  logic [7:0]  a8, b8, result8, hi8;
  logic [3:0]  op32, op8;
  logic        zero32, ovf32, busy32, done32;
  logic        zero8, ovf8, busy8, done8;

  seq_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .a(a32), .b(b32),
    .alu_control(op32), .result(result32), .hi(hi32), .zero(zero32),
    .overflow(ovf32), .busy(busy32), .done(done32)
  );

  seq_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8),
    .alu_control(op8), .result(result8), .hi(hi8), .zero(zero8),
    .overflow(ovf8), .busy(busy8), .done(done8)
  );

  typedef struct {
    logic [63:0] res;
    logic [63:0] hi;
    bit          ovf;
    bit          zero;
    int          lat;
    longint      issue;
  } expT;

  expT         q32[$];
  expT         q8[$];
  logic [63:0] hiModel[2];
  longint      cycle = 0;
  int          nChecks = 0;
  int          nFails = 0;
  int          doneCount8 = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Reference model: plain arithmetic on wide integers, masked to the width.
  function automatic expT model(int w, logic [3:0] op, logic [63:0] x, logic [63:0] y,
                                logic [63:0] hiPrev);
    expT         e;
    logic [63:0] mask, p;
    longint      sx, sy, s, lim;
    mask = (64'd1 << w) - 64'd1;
    lim  = longint'(64'd1 << (w - 1));
    sx   = x[w-1] ? longint'(x) - longint'(64'd1 << w) : longint'(x);
    sy   = y[w-1] ? longint'(y) - longint'(64'd1 << w) : longint'(y);
    e.res = 64'd0; e.hi = hiPrev; e.ovf = 1'b0; e.lat = 1; e.issue = 0;
    case (op)
      4'b0000: e.res = x & y;
      4'b0001: e.res = x | y;
      4'b0010: begin s = sx + sy; e.res = (x + y) & mask; e.ovf = (s >= lim) || (s < -lim); end
      4'b0110: begin s = sx - sy; e.res = (x - y) & mask; e.ovf = (s >= lim) || (s < -lim); end
      4'b0111: e.res = (sx < sy) ? 64'd1 : 64'd0;
      4'b1000: e.res = (x < y) ? 64'd1 : 64'd0;
      4'b1100: e.res = ~(x | y) & mask;
      4'b1001: begin p = x * y; e.res = p & mask; e.hi = (p >> w) & mask; e.lat = w + 1; end
      4'b1010: begin
        if (DIV_EN) begin
          e.lat = w + 1;
          if (y == 64'd0) begin e.res = mask; e.hi = x; end
          else begin e.res = x / y; e.hi = x % y; end
        end
      end
      default: ;
    endcase
    e.zero = (e.res == 64'd0);
    return e;
  endfunction

  function automatic logic [63:0] randOperand(int w);
    logic [63:0] mask;
    mask = (64'd1 << w) - 64'd1;
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return 64'd1;
      2:       return mask;
      3:       return 64'd1 << (w - 1);
      default: return {$urandom(), $urandom()} & mask;
    endcase
  endfunction

  function automatic logic [3:0] randOp();
    if ($urandom_range(0, 3) == 0) return ($urandom_range(0, 1) == 0) ? 4'b1001 : 4'b1010;
    return 4'($urandom_range(0, 15));
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(string tag, expT e, logic [63:0] r, logic [63:0] h, logic z, logic o);
    check({tag, " latency"}, 64'(cycle - e.issue), 64'(e.lat));
    check({tag, " result"}, r, e.res);
    check({tag, " hi"}, h, e.hi);
    check({tag, " zero"}, 64'(z), 64'(e.zero));
    check({tag, " overflow"}, 64'(o), 64'(e.ovf));
  endtask

  // Monitors: pop the oldest expectation whenever a done pulse is seen.
  always @(negedge clk) begin
    if (done32 === 1'b1) begin
      if (q32.size() == 0) begin
        nChecks++; nFails++;
        $display("[TB] FAIL w32 done: got unexpected pulse, expected none");
      end else begin
        checkOutput("w32", q32.pop_front(), 64'(result32), 64'(hi32), zero32, ovf32);
      end
    end
  end

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      doneCount8++;
      if (q8.size() == 0) begin
        nChecks++; nFails++;
        $display("[TB] FAIL w8 done: got unexpected pulse, expected none");
      end else begin
        checkOutput("w8", q8.pop_front(), 64'(result8), 64'(hi8), zero8, ovf8);
      end
    end
  end

  task automatic applyStimulus(bit sel, logic [3:0] op, logic [63:0] x, logic [63:0] y);
    expT e;
    int  guard;
    @(negedge clk);
    guard = 0;
    while ((sel ? busy8 : busy32) === 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      nChecks++; nFails++;
      $display("[TB] FAIL busy timeout: got busy after %0d cycles, expected idle", guard);
    end
    e = model(sel ? 8 : 32, op, x, y, hiModel[sel]);
    hiModel[sel] = e.hi;
    e.issue = cycle;
    if (sel) begin
      start8 = 1'b1; a8 = x[7:0]; b8 = y[7:0]; op8 = op; q8.push_back(e);
    end else begin
      start32 = 1'b1; a32 = x[31:0]; b32 = y[31:0]; op32 = op; q32.push_back(e);
    end
    @(posedge clk);
    #1;
    if (sel) start8 = 1'b0; else start32 = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((q32.size() != 0 || q8.size() != 0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("pending expectations", 64'(q32.size() + q8.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int busyCycles;
    int doneBase;
    start32 = 1'b0; a32 = '0; b32 = '0; op32 = '0;
    start8  = 1'b0; a8  = '0; b8  = '0; op8  = '0;
    hiModel[0] = 64'd0;
    hiModel[1] = 64'd0;

    repeat (2) @(posedge clk);
    #1;
    check("reset result", 64'(result32), 64'd0);
    check("reset hi", 64'(hi32), 64'd0);
    check("reset zero", 64'(zero32), 64'd1);
    check("reset overflow", 64'(ovf32), 64'd0);
    check("reset busy", 64'(busy32), 64'd0);
    check("reset done", 64'(done32), 64'd0);
    check("reset zero w8", 64'(zero8), 64'd1);
    reset = 1'b0;

    applyStimulus(0, 4'b0010, 64'h7FFF_FFFF, 64'd1);
    applyStimulus(0, 4'b0111, 64'hFFFF_FFFF, 64'd1);
    applyStimulus(0, 4'b1000, 64'hFFFF_FFFF, 64'd1);
    applyStimulus(0, 4'b1100, 64'd0, 64'd0);

    applyStimulus(0, 4'b1001, 64'hFFFF_FFFF, 64'd2);
    busyCycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy32 !== 1'b1) break;
      busyCycles++;
      if (busyCycles == 10) begin
        start32 = 1'b1; op32 = 4'b0010; a32 = 32'd5; b32 = 32'd6;
      end
      if (busyCycles == 11) start32 = 1'b0;
    end
    check("multu busy cycles", 64'(busyCycles), 64'd32);

    applyStimulus(0, 4'b1010, 64'd100, 64'd7);
    applyStimulus(0, 4'b1010, 64'd5, 64'd0);

    applyStimulus(0, 4'b1001, randOperand(32), randOperand(32));
    repeat (9) @(negedge clk);
    reset = 1'b1;
    q32.delete();
    hiModel[0] = 64'd0;
    @(posedge clk);
    #1;
    check("abort done", 64'(done32), 64'd0);
    check("abort busy", 64'(busy32), 64'd0);
    check("abort result", 64'(result32), 64'd0);
    check("abort zero", 64'(zero32), 64'd1);
    reset = 1'b0;
    applyStimulus(0, 4'b0010, 64'd3, 64'd4);

    for (int i = 0; i < 60; i++) applyStimulus(0, randOp(), randOperand(32), randOperand(32));
    drain();

    doneBase = doneCount8;
    applyStimulus(1, 4'b0110, 64'd0, 64'd1);
    for (int i = 0; i < 30; i++)
      applyStimulus(1, (i % 2 == 0) ? 4'b0010 : 4'b0110, randOperand(8), randOperand(8));
    drain();
    check("w8 back-to-back done count", 64'(doneCount8 - doneBase), 64'd31);

    for (int i = 0; i < 30; i++) applyStimulus(1, randOp(), randOperand(8), randOperand(8));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The parameter SHALL be: WIDTH, default 32, operand/result width in bits (legal 8..64).
REQ-002 The port list SHALL be: clk  input  1  rising-edge clock for all state.
REQ-003 The port list SHALL be: reset  input  1  synchronous, active-high reset.
REQ-004 The port list SHALL be: start  input  1  operation request, sampled on clk rising edge.
REQ-005 The port list SHALL be: a  input  WIDTH  operand A.
REQ-006 The port list SHALL be: b  input  WIDTH  operand B.
REQ-007 The port list SHALL be: alu_control  input  4  operation select.
REQ-008 The port list SHALL be: result  output  WIDTH  registered result (low word for multu/divu).
REQ-009 The port list SHALL be: hi  output  WIDTH  product high word or remainder.
REQ-010 The port list SHALL be: zero  output  1  high when result is all zeros.
REQ-011 The port list SHALL be: overflow  output  1  signed overflow of the last add/sub.
REQ-012 The port list SHALL be: busy  output  1  multi-cycle operation in progress.
REQ-013 The port list SHALL be: done  output  1  one-cycle pulse; result, hi, zero and overflow valid.

Function
REQ-014 Op codes SHALL be: 0000 and; 0001 or; 0010 add; 0110 sub; 0111 slt (signed); 1000 sltu; 1100 nor; 1001 multu; 1010 divu.
REQ-015 A start SHALL be accepted only on an edge where busy=0; start while busy=1 is ignored, with no queuing.
REQ-016 a, b and alu_control SHALL be latched at acceptance; input changes during busy SHALL have no effect.
REQ-017 The FSM states SHALL be IDLE, MUL, DIV; transitions: IDLE->MUL on accepted 1001, IDLE->DIV on accepted 1010, MUL/DIV->IDLE after exactly WIDTH iterations, and all other accepted codes stay in IDLE.
REQ-018 Single-cycle ops SHALL register result and done=1 at the accepting edge: latency 1 cycle, back-to-back throughput 1 op per cycle.
REQ-019 multu/divu SHALL assert busy from the accepting edge until the final iteration edge, with done=1 for the cycle after that edge: latency WIDTH+1 cycles.
REQ-020 multu SHALL produce {hi,result} equal to the unsigned 2*WIDTH-bit product via shift-add, one bit per cycle.
REQ-021 divu SHALL produce result = a/b and hi = a%b (unsigned) via restoring division, one bit per cycle.
REQ-022 divu with b=0 SHALL produce result = all ones and hi = a, with unchanged latency.
REQ-023 Arithmetic SHALL wrap modulo 2^WIDTH.
REQ-024 overflow SHALL be updated only by add/sub and cleared by every other completed op.
REQ-025 hi SHALL be updated only by multu/divu.
REQ-026 Undefined codes SHALL complete in 1 cycle with result=0 and hi unchanged.
REQ-027 result, hi, zero and overflow SHALL hold their values until the next completed op.
REQ-028 done SHALL be low in every cycle not specified above.
REQ-029 zero SHALL be computed from the registered result.

Reset
REQ-030 reset=1 at a clk edge SHALL force state IDLE and result, hi, overflow, busy and done to 0, and zero to 1.
REQ-031 reset SHALL take priority over start, including an in-flight multu/divu, which is abandoned with no done pulse.
REQ-032 A start presented on the first edge after reset deasserts SHALL be accepted.

Configuration
REQ-033 With macro SEQ_ALU_DIV_EN defined, the DIV state and divider datapath SHALL be compiled in and code 1010 SHALL behave per REQ-021/022.
REQ-034 With SEQ_ALU_DIV_EN undefined, no divider logic SHALL be synthesised and code 1010 SHALL behave as an undefined code per REQ-026.

Verification
REQ-035 The bench SHALL cover: WIDTH=32, add a=0x7FFFFFFF b=1 -> done after 1 cycle, result=0x80000000, overflow=1, zero=0.
REQ-036 The bench SHALL cover: slt a=0xFFFFFFFF b=1 -> result=1; sltu with the same operands -> result=0; nor a=0 b=0 -> result=0xFFFFFFFF.
REQ-037 The bench SHALL cover: multu a=0xFFFFFFFF b=2 -> busy for 32 cycles, done at cycle 33, hi=1, result=0xFFFFFFFE; a start pulse mid-operation is ignored.
REQ-038 The bench SHALL cover, with DIV_EN defined: divu a=100 b=7 -> result=14, hi=2; divu b=0 a=5 -> result=0xFFFFFFFF, hi=5. With DIV_EN undefined: 1010 -> result=0 after 1 cycle.
REQ-039 The bench SHALL cover: reset asserted at cycle 10 of a multu -> no done pulse, busy=0, result=0, zero=1 on the next cycle; a new add 3+4 then returns 7.
REQ-040 The bench SHALL cover: WIDTH=8 back-to-back add/sub on consecutive cycles -> one done per cycle; sub 0x00-0x01 -> 0xFF with overflow=0.
